// File: rtl/mem_stage.sv
// EX/MEM pipeline latch plus memory-access stage: registers execute results and runs
// a single outstanding req/ack data-bus transaction for loads and stores.
module mem_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic [4:0]      ex_wd_i,
  input  logic            ex_wreg_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [3:0]      ex_memop_i,
  input  logic [31:0]     ex_hi_i,
  input  logic [31:0]     ex_lo_i,
  input  logic            ex_whilo_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_sel_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o,
  output logic            whilo_o,
  output logic            stallreq_from_mem_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  state_e          state_q;
  logic [15:0]     cnt_q;
  size_e           size_q;
  logic            is_unsigned_q;
  logic            is_store_q;
  logic [2:0]      addr_lo_q;
  logic            wreg_cap_q;
  logic            whilo_cap_q;

  logic            mem_valid, is_store, is_unsigned, misaligned;
  size_e           size;
  logic [7:0]      sel_d;
  logic [XLEN-1:0] lane_wdata_d;
  logic [XLEN-1:0] shifted, load_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_valid   = 1'b1;
    is_store    = 1'b0;
    is_unsigned = 1'b0;
    size        = SZ_B;
    case (ex_memop_i)
      4'd1:    size = SZ_B;
      4'd2:    size = SZ_H;
      4'd3:    size = SZ_W;
      4'd4:    size = SZ_D;
      4'd5:    begin size = SZ_B; is_unsigned = 1'b1; end
      4'd6:    begin size = SZ_H; is_unsigned = 1'b1; end
      4'd7:    begin size = SZ_W; is_unsigned = 1'b1; end
      4'd8:    begin size = SZ_B; is_store = 1'b1; end
      4'd9:    begin size = SZ_H; is_store = 1'b1; end
      4'd10:   begin size = SZ_W; is_store = 1'b1; end
      4'd11:   begin size = SZ_D; is_store = 1'b1; end
      default: mem_valid = 1'b0;
    endcase

    misaligned   = 1'b0;
    sel_d        = 8'hFF;
    lane_wdata_d = ex_wdata_i;
    case (size)
      SZ_B: begin
        sel_d        = 8'h01 << ex_addr_i[2:0];
        lane_wdata_d = {(XLEN/8){ex_wdata_i[7:0]}};
      end
      SZ_H: begin
        misaligned   = ex_addr_i[0];
        sel_d        = 8'h03 << ex_addr_i[2:0];
        lane_wdata_d = {(XLEN/16){ex_wdata_i[15:0]}};
      end
      SZ_W: begin
        misaligned   = |ex_addr_i[1:0];
        sel_d        = 8'h0F << ex_addr_i[2:0];
        lane_wdata_d = {(XLEN/32){ex_wdata_i[31:0]}};
      end
      default: misaligned = |ex_addr_i[2:0];
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by size and signedness.
  always_comb begin
    shifted = dmem_rdata_i >> {addr_lo_q, 3'b000};
    case (size_q)
      SZ_B:    load_data = {{(XLEN-8){~is_unsigned_q & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{(XLEN-16){~is_unsigned_q & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = {{(XLEN-32){~is_unsigned_q & shifted[31]}}, shifted[31:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // NOTE: the asynchronous reset clears every flop here (no storage arrays), so a reset
  // mid-transaction drops dmem_req_o at once and any later ack lands in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      size_q              <= SZ_B;
      is_unsigned_q       <= 1'b0;
      is_store_q          <= 1'b0;
      addr_lo_q           <= '0;
      wreg_cap_q          <= 1'b0;
      whilo_cap_q         <= 1'b0;
      dmem_req_o          <= 1'b0;
      dmem_we_o           <= 1'b0;
      dmem_addr_o         <= '0;
      dmem_wdata_o        <= '0;
      dmem_sel_o          <= '0;
      wd_o                <= '0;
      wreg_o              <= 1'b0;
      wdata_o             <= '0;
      hi_o                <= '0;
      lo_o                <= '0;
      whilo_o             <= 1'b0;
      stallreq_from_mem_o <= 1'b0;
      misalign_o          <= 1'b0;
      bus_err_o           <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          wd_o    <= ex_wd_i;
          hi_o    <= ex_hi_i;
          lo_o    <= ex_lo_i;
          wreg_o  <= 1'b0;
          whilo_o <= 1'b0;
          wdata_o <= '0;
          if (stall_i) begin
            wd_o <= '0;
            hi_o <= '0;
            lo_o <= '0;
          end else if (!mem_valid) begin
            wreg_o  <= ex_wreg_i;
            whilo_o <= ex_whilo_i;
            wdata_o <= ex_wdata_i;
          end else if (misaligned) begin
            misalign_o <= 1'b1;
          end else begin
            state_q             <= BUSY;
            size_q              <= size;
            is_unsigned_q       <= is_unsigned;
            is_store_q          <= is_store;
            addr_lo_q           <= ex_addr_i[2:0];
            wreg_cap_q          <= ex_wreg_i;
            whilo_cap_q         <= ex_whilo_i;
            dmem_req_o          <= 1'b1;
            dmem_we_o           <= is_store;
            dmem_addr_o         <= {ex_addr_i[XLEN-1:3], 3'b000};
            dmem_wdata_o        <= lane_wdata_d;
            dmem_sel_o          <= sel_d;
            stallreq_from_mem_o <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack_i || cnt_q == 16'(TIMEOUT - 1)) begin
            state_q             <= IDLE;
            dmem_req_o          <= 1'b0;
            dmem_we_o           <= 1'b0;
            dmem_addr_o         <= '0;
            dmem_wdata_o        <= '0;
            dmem_sel_o          <= '0;
            stallreq_from_mem_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
          // An ack in the timeout cycle still completes the transfer.
          if (dmem_ack_i) begin
            wreg_o  <= wreg_cap_q & ~is_store_q;
            wdata_o <= is_store_q ? '0 : load_data;
            whilo_o <= whilo_cap_q;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            bus_err_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, bubbles, loads, stores, errors, reset.
module tb_mem_stage;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LW = 4'd3, OP_LD = 4'd4,
                         OP_LBU = 4'd5, OP_LWU = 4'd7, OP_SH = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic [4:0]  ex_wd_i = '0;
  logic        ex_wreg_i = 1'b0;
  logic [63:0] ex_wdata_i = '0;
  logic [63:0] ex_addr_i = '0;
  logic [3:0]  ex_memop_i = '0;
  logic [31:0] ex_hi_i = '0;
  logic [31:0] ex_lo_i = '0;
  logic        ex_whilo_i = 1'b0;
  logic        dmem_ack_i = 1'b0;
  logic [63:0] dmem_rdata_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_sel_o;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_from_mem_o, misalign_o, bus_err_o;
  logic [63:0] wdata_o;
  logic [31:0] hi_o, lo_o;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_addr_i(ex_addr_i), .ex_memop_i(ex_memop_i), .ex_hi_i(ex_hi_i),
    .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_sel_o(dmem_sel_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .stallreq_from_mem_o(stallreq_from_mem_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_inputs();
    ex_memop_i = OP_NONE;
    ex_wreg_i  = 1'b0;
    ex_whilo_i = 1'b0;
    ex_wd_i    = '0;
    ex_wdata_i = '0;
    ex_addr_i  = '0;
  endtask

  // Present one instruction for one edge, then fall back to a nop.
  task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] wd, input logic wreg, input logic whilo,
                       input logic [31:0] hi, input logic [31:0] lo);
    ex_memop_i = op; ex_addr_i = addr; ex_wdata_i = wdata; ex_wd_i = wd;
    ex_wreg_i = wreg; ex_whilo_i = whilo; ex_hi_i = hi; ex_lo_i = lo;
    step();
    nop_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({dmem_req_o, stallreq_from_mem_o, wreg_o, whilo_o, misalign_o, bus_err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000",
               {dmem_req_o, stallreq_from_mem_o, wreg_o, whilo_o, misalign_o, bus_err_o});
    end
    tests_run++;
    if ({wdata_o, dmem_addr_o, dmem_wdata_o} !== 192'b0 || dmem_sel_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: wdata=%h addr=%h sel=%h want zeros", wdata_o, dmem_addr_o, dmem_sel_o);
    end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_pass();
    issue(OP_NONE, 64'h0, 64'h1234, 5'd5, 1'b1, 1'b1, 32'hCAFE_0001, 32'hBEEF_0002);
    tests_run++;
    if (wd_o !== 5'd5 || wreg_o !== 1'b1 || wdata_o !== 64'h1234) begin
      tests_failed++;
      $display("FAIL alu_pass: wd=%0d wreg=%b wdata=%h want 5 1 1234", wd_o, wreg_o, wdata_o);
    end
    tests_run++;
    if (stallreq_from_mem_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_stall: stall=%b req=%b want 0 0", stallreq_from_mem_o, dmem_req_o);
    end
    tests_run++;
    if (whilo_o !== 1'b1 || hi_o !== 32'hCAFE_0001 || lo_o !== 32'hBEEF_0002) begin
      tests_failed++;
      $display("FAIL alu_hilo: whilo=%b hi=%h lo=%h want 1 cafe0001 beef0002", whilo_o, hi_o, lo_o);
    end
  endtask

  task automatic test_stall_bubble();
    stall_i = 1'b1;
    issue(OP_LW, 64'h100, 64'h77, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2);
    stall_i = 1'b0;
    tests_run++;
    if (wreg_o !== 1'b0 || whilo_o !== 1'b0 || wdata_o !== 64'h0 || dmem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_bubble: wreg=%b whilo=%b wdata=%h req=%b want 0 0 0 0",
               wreg_o, whilo_o, wdata_o, dmem_req_o);
    end
    step();
  endtask

  task automatic test_lb();
    int stall_cycles = 0;
    issue(OP_LB, 64'h1003, 64'h0, 5'd7, 1'b1, 1'b1, 32'hAAAA, 32'h5555);
    tests_run++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_sel_o !== 8'h08 || dmem_addr_o !== 64'h1000) begin
      tests_failed++;
      $display("FAIL lb_req: req=%b we=%b sel=%h addr=%h want 1 0 08 1000",
               dmem_req_o, dmem_we_o, dmem_sel_o, dmem_addr_o);
    end
    tests_run++;
    if (wreg_o !== 1'b0 || whilo_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb_busy_wreg: wreg=%b whilo=%b want 0 0", wreg_o, whilo_o);
    end
    for (int i = 0; i < 3; i++) begin
      if (stallreq_from_mem_o === 1'b1) stall_cycles++;
      if (i == 2) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h0000_0000_8000_0000;
      end
      step();
    end
    dmem_ack_i = 1'b0;
    tests_run++;
    if (stall_cycles != 3) begin
      tests_failed++;
      $display("FAIL lb_stall_len: got %0d cycles want 3", stall_cycles);
    end
    tests_run++;
    if (wreg_o !== 1'b1 || wdata_o !== 64'hFFFF_FFFF_FFFF_FF80 || wd_o !== 5'd7) begin
      tests_failed++;
      $display("FAIL lb_result: wreg=%b wdata=%h wd=%0d want 1 ffffffffffffff80 7", wreg_o, wdata_o, wd_o);
    end
    tests_run++;
    if (whilo_o !== 1'b1 || hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
      tests_failed++;
      $display("FAIL lb_hilo: whilo=%b hi=%h lo=%h want 1 aaaa 5555", whilo_o, hi_o, lo_o);
    end
    tests_run++;
    if (stallreq_from_mem_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb_release: stall=%b req=%b want 0 0", stallreq_from_mem_o, dmem_req_o);
    end
  endtask

  task automatic test_lw_lwu();
    issue(OP_LWU, 64'h4, 64'h0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (dmem_sel_o !== 8'hF0) begin
      tests_failed++;
      $display("FAIL lwu_sel: got %h want f0", dmem_sel_o);
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h8765_4321_0000_0000;
    step();
    dmem_ack_i = 1'b0;
    tests_run++;
    if (wdata_o !== 64'h0000_0000_8765_4321 || wreg_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL lwu_data: wdata=%h wreg=%b want 0000000087654321 1", wdata_o, wreg_o);
    end
    issue(OP_LW, 64'h4, 64'h0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0);
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    tests_run++;
    if (wdata_o !== 64'hFFFF_FFFF_8765_4321) begin
      tests_failed++;
      $display("FAIL lw_data: got %h want ffffffff87654321", wdata_o);
    end
  endtask

  task automatic test_sh();
    issue(OP_SH, 64'h6, 64'hFFFF_0000_ABCD, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (dmem_we_o !== 1'b1 || dmem_sel_o !== 8'hC0 || dmem_wdata_o !== 64'hABCD_ABCD_ABCD_ABCD
        || dmem_addr_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL sh_req: we=%b sel=%h wdata=%h addr=%h want 1 c0 abcdabcdabcdabcd 0",
               dmem_we_o, dmem_sel_o, dmem_wdata_o, dmem_addr_o);
    end
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    tests_run++;
    if (wreg_o !== 1'b0 || stallreq_from_mem_o !== 1'b0 || dmem_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sh_done: wreg=%b stall=%b we=%b want 0 0 0", wreg_o, stallreq_from_mem_o, dmem_we_o);
    end
  endtask

  // BUSY ignores stall_i; the completion cycle accepts the next instruction.
  task automatic test_back_to_back();
    issue(OP_LBU, 64'h2, 64'h0, 5'd11, 1'b1, 1'b0, 32'h0, 32'h0);
    stall_i = 1'b1;
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h0000_0000_00F1_0000;
    step();
    dmem_ack_i = 1'b0; stall_i = 1'b0;
    tests_run++;
    if (wdata_o !== 64'h0000_0000_0000_00F1 || wreg_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL lbu_data: wdata=%h wreg=%b want f1 1", wdata_o, wreg_o);
    end
    issue(OP_NONE, 64'h0, 64'h55AA, 5'd12, 1'b1, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (wdata_o !== 64'h55AA || wd_o !== 5'd12 || wreg_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_alu: wdata=%h wd=%0d wreg=%b want 55aa 12 1", wdata_o, wd_o, wreg_o);
    end
  endtask

  task automatic test_misalign();
    issue(OP_LW, 64'h2, 64'h0, 5'd6, 1'b1, 1'b1, 32'h0, 32'h0);
    tests_run++;
    if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0 || wreg_o !== 1'b0 || whilo_o !== 1'b0
        || stallreq_from_mem_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign: mis=%b req=%b wreg=%b whilo=%b stall=%b want 1 0 0 0 0",
               misalign_o, dmem_req_o, wreg_o, whilo_o, stallreq_from_mem_o);
    end
    step();
    tests_run++;
    if (misalign_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_pulse: got %b want 0", misalign_o);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    issue(OP_LD, 64'h8, 64'h0, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    while (dmem_req_o === 1'b1 && req_cycles < 10) begin
      req_cycles++;
      step();
    end
    tests_run++;
    if (req_cycles != 4) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d req cycles want 4", req_cycles);
    end
    tests_run++;
    if (bus_err_o !== 1'b1 || wreg_o !== 1'b0 || stallreq_from_mem_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_err: err=%b wreg=%b stall=%b want 1 0 0", bus_err_o, wreg_o, stallreq_from_mem_o);
    end
    step();
    tests_run++;
    if (bus_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got %b want 0", bus_err_o);
    end
  endtask

  task automatic test_ack_at_timeout();
    issue(OP_LW, 64'h8, 64'h0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    step(); step(); step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h1111_2222_3333_4444;
    step();
    dmem_ack_i = 1'b0;
    tests_run++;
    if (bus_err_o !== 1'b0 || wreg_o !== 1'b1 || wdata_o !== 64'h0000_0000_3333_4444) begin
      tests_failed++;
      $display("FAIL ack_at_timeout: err=%b wreg=%b wdata=%h want 0 1 0000000033334444",
               bus_err_o, wreg_o, wdata_o);
    end
  endtask

  task automatic test_reset_busy();
    issue(OP_LB, 64'h20, 64'h0, 5'd8, 1'b1, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (dmem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstbusy_req: got %b want 1", dmem_req_o);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (dmem_req_o !== 1'b0 || stallreq_from_mem_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstbusy_async: req=%b stall=%b want 0 0", dmem_req_o, stallreq_from_mem_o);
    end
    rst = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hFF;
    step(); step();
    dmem_ack_i = 1'b0;
    tests_run++;
    if (wreg_o !== 1'b0 || dmem_req_o !== 1'b0 || wdata_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL rstbusy_late_ack: wreg=%b req=%b wdata=%h want 0 0 0", wreg_o, dmem_req_o, wdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_stall_bubble();
    test_lb();
    test_lw_lwu();
    test_sh();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
